// File: rtl/branch_seq.sv
// branch_seq: fetch-and-conditional-branch control sequencer.
// Steps the datapath through a T0..T6 instruction fetch and branch sequence.
// It evaluates the IR condition field against the bus value in T3.
// With SKIP_NOT_TAKEN set, a not-taken branch finishes straight after T3.
// Optional build macro BRANCH_SEQ_STATS_EN adds saturating taken/total counters.
module branch_seq #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned SKIP_NOT_TAKEN = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] bus_data,
  input  logic [1:0]        c2,
  output logic              PCout,
  output logic              MARin,
  output logic              IncPC,
  output logic              Read,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Gra,
  output logic              Rout,
  output logic              CONin,
  output logic              Yin,
  output logic              Cout,
  output logic              BRANCH,
  output logic              Zin,
  output logic              Zlowout,
  output logic              PCin,
  output logic              con_ff,
  output logic              busy,
  output logic              done
`ifdef BRANCH_SEQ_STATS_EN
  ,
  output logic [15:0]       taken_cnt,
  output logic [15:0]       total_cnt
`endif
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, DONE
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic gra;
    logic r_out;
    logic con_in;
    logic y_in;
    logic c_out;
    logic branch;
    logic z_in;
    logic zlow_out;
    logic pc_in;
  } strb_t;

  state_t state_q, state_d;
  strb_t  strb_q, strb_d;
  logic   con_ff_q, con_ff_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   cond;

  // Branch condition on the current bus value, selected by the IR field.
  always_comb begin
    cond = 1'b0;
    unique case (c2)
      2'b00: cond = (bus_data == '0);
      2'b01: cond = (bus_data != '0);
      2'b10: cond = !bus_data[DATA_W-1] && (bus_data != '0);
      2'b11: cond = bus_data[DATA_W-1];
      default: cond = 1'b0;
    endcase
  end

  // Next state plus strobes decoded from that next state, so outputs register in step with state.
  always_comb begin
    state_d  = state_q;
    con_ff_d = con_ff_q;
    unique case (state_q)
      IDLE: if (start) state_d = T0;
      T0:   state_d = T1;
      T1:   if (mem_ack) state_d = T2;
      T2:   state_d = T3;
      T3: begin
        con_ff_d = cond;
        if ((SKIP_NOT_TAKEN != 0) && !cond) state_d = DONE;
        else                                state_d = T4;
      end
      T4:   state_d = T5;
      T5:   state_d = T6;
      T6:   state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    strb_d = '0;
    unique case (state_d)
      T0: begin
        strb_d.pc_out = 1'b1;
        strb_d.mar_in = 1'b1;
      end
      T1: begin
        strb_d.inc_pc = (state_q == T0);
        strb_d.read   = 1'b1;
        strb_d.mdr_in = 1'b1;
      end
      T2: begin
        strb_d.mdr_out = 1'b1;
        strb_d.ir_in   = 1'b1;
      end
      T3: begin
        strb_d.gra    = 1'b1;
        strb_d.r_out  = 1'b1;
        strb_d.con_in = 1'b1;
      end
      T4: begin
        strb_d.pc_out = 1'b1;
        strb_d.y_in   = 1'b1;
      end
      T5: begin
        strb_d.c_out  = 1'b1;
        strb_d.z_in   = 1'b1;
        strb_d.branch = 1'b1;
      end
      T6: begin
        strb_d.zlow_out = 1'b1;
        strb_d.pc_in    = con_ff_d;
      end
      default: strb_d = '0;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      strb_q   <= '0;
      con_ff_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      strb_q   <= strb_d;
      con_ff_q <= con_ff_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign PCout   = strb_q.pc_out;
  assign MARin   = strb_q.mar_in;
  assign IncPC   = strb_q.inc_pc;
  assign Read    = strb_q.read;
  assign MDRin   = strb_q.mdr_in;
  assign MDRout  = strb_q.mdr_out;
  assign IRin    = strb_q.ir_in;
  assign Gra     = strb_q.gra;
  assign Rout    = strb_q.r_out;
  assign CONin   = strb_q.con_in;
  assign Yin     = strb_q.y_in;
  assign Cout    = strb_q.c_out;
  assign BRANCH  = strb_q.branch;
  assign Zin     = strb_q.z_in;
  assign Zlowout = strb_q.zlow_out;
  assign PCin    = strb_q.pc_in;
  assign con_ff  = con_ff_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef BRANCH_SEQ_STATS_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] total_cnt_q, total_cnt_d;

  // Counters step as DONE is entered, so they are current when done is seen.
  always_comb begin
    taken_cnt_d = taken_cnt_q;
    total_cnt_d = total_cnt_q;
    if (state_d == DONE) begin
      if (total_cnt_q != '1)             total_cnt_d = total_cnt_q + 16'd1;
      if (con_ff_d && taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + 16'd1;
    end
  end

  // Saturating statistics registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      taken_cnt_q <= '0;
      total_cnt_q <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
      total_cnt_q <= total_cnt_d;
    end
  end

  assign taken_cnt = taken_cnt_q;
  assign total_cnt = total_cnt_q;
`endif

endmodule

// File: doc/branch_seq.md
BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the datapath bus width in bits.
REQ-002 SHALL have parameter SKIP_NOT_TAKEN, default 1; when set, a not-taken branch terminates after T3.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-004 SHALL have port clr, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle pulse that begins one fetch-and-branch sequence.
REQ-006 SHALL have port mem_ack, input, 1 bit: memory read data valid in MDR path.
REQ-007 SHALL have port bus_data, input, DATA_W bits: BusMuxOut value, sampled in T3.
REQ-008 SHALL have port c2, input, 2 bits: IR condition field; 00 zero, 01 nonzero, 10 positive, 11 negative.
REQ-009 SHALL have outputs PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Gra, Rout, CONin, Yin, Cout, BRANCH, Zin, Zlowout, PCin, each 1 bit: datapath control strobes.
REQ-010 SHALL have outputs con_ff (1 bit, registered branch condition), busy (1 bit) and done (1 bit, one-cycle completion pulse).

Function
REQ-011 SHALL implement FSM states IDLE, T0, T1, T2, T3, T4, T5, T6, DONE; all strobes SHALL be registered outputs decoded from the next state.
REQ-012 IDLE: start=1 -> T0; otherwise hold; busy=0 only in IDLE.
REQ-013 T0 asserts PCout, MARin; -> T1 unconditionally.
REQ-014 T1 asserts IncPC for exactly its first cycle and holds Read, MDRin every cycle; stays in T1 until mem_ack=1, then -> T2.
REQ-015 T2 asserts MDRout, IRin; -> T3.
REQ-016 T3 asserts Gra, Rout, CONin; at the T3 clock edge con_ff loads cond(bus_data, c2).
REQ-017 cond SHALL be: 00 -> bus_data==0; 01 -> bus_data!=0; 10 -> MSB==0 and bus_data!=0; 11 -> MSB==1; evaluation width DATA_W.
REQ-018 After T3: if SKIP_NOT_TAKEN=1 and the new con_ff=0 -> DONE; else -> T4.
REQ-019 T4 asserts PCout, Yin; T5 asserts Cout, Zin, and BRANCH; T6 asserts Zlowout, and asserts PCin only if con_ff=1.
REQ-020 T6 -> DONE; DONE pulses done=1 for one cycle and returns to IDLE.
REQ-021 start while busy=1 SHALL be ignored, with no queueing.
REQ-022 No two of PCout, MDRout, Rout, Zlowout, Cout SHALL be asserted in the same cycle, giving a single bus driver.
REQ-023 Sequence latency with mem_ack on the first T1 cycle: taken, start to done = 9 cycles; not-taken with skip = 6 cycles.

Reset
REQ-024 clr=0 SHALL immediately force state IDLE, con_ff=0, busy=0, done=0 and all strobes 0, including mid-sequence.
REQ-025 After clr is released, the first action SHALL require a fresh start pulse.

Configuration
REQ-026 Macro BRANCH_SEQ_STATS_EN: when defined, the block SHALL add output taken_cnt (16 bits) and output total_cnt (16 bits).
REQ-027 When BRANCH_SEQ_STATS_EN is defined, total_cnt SHALL increment on each DONE and taken_cnt SHALL increment on each DONE with con_ff=1.
REQ-028 When BRANCH_SEQ_STATS_EN is defined, both counters SHALL saturate at 16'hFFFF and clear on clr=0.
REQ-029 When BRANCH_SEQ_STATS_EN is undefined, these ports and their registers SHALL be absent and behaviour SHALL be otherwise identical.

Verification
REQ-030 c2=10, bus_data=32'hFFFFDEBD, mem_ack immediate -> con_ff=0, DONE after T3, PCin never asserted, done at cycle 6.
REQ-031 c2=11, bus_data=32'hFFFFDEBD -> con_ff=1, T4-T6 traversed, PCin=1 with Zlowout in T6, done at cycle 9.
REQ-032 c2=00, bus_data=0, SKIP_NOT_TAKEN=0; then c2=01, bus_data=0 -> first run taken, second run not-taken but still passes T6 with PCin=0.
REQ-033 mem_ack delayed 3 cycles -> Read and MDRin held 4 cycles, IncPC high exactly 1 cycle, done delayed by 3.
REQ-034 clr=0 asserted during T5 -> all outputs 0 asynchronously; a start pulse during busy is ignored; with STATS_EN, counters read 0 after reset.
